// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider
//  Description : Programmable divider producing the slow display-scan clock
//                clk_div (50% duty, H cycles high / H cycles low) and a
//                one-cycle tick strobe in the clk domain on each clk_div rise.
//                The half-period is resampled only at toggle boundaries, so a
//                change never produces a short or stretched half.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider #(
    parameter int WIDTH        = 26,
    parameter int DEFAULT_HALF = 25000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] half_period,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [WIDTH-1:0] c_one          = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_default_half = WIDTH'(DEFAULT_HALF);
    // A zero default would leave the counter with no terminal count.
    localparam logic [WIDTH-1:0] c_reset_half   =
        (c_default_half == '0) ? c_one : c_default_half;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_active_half;

    logic [WIDTH-1:0] w_last_cnt;
    logic             w_terminal;
    logic [WIDTH-1:0] w_next_half;

    // r_active_half is never 0, so the subtraction cannot wrap and r_cnt can
    // never run past the terminal count, even at the maximum half-period.
    assign w_last_cnt  = r_active_half - c_one;
    assign w_terminal  = (r_cnt == w_last_cnt);
    assign w_next_half = (half_period == '0) ? c_one : half_period;

    // Half-period counter, toggle register and rising-edge strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_active_half <= c_reset_half;
            clk_div       <= 1'b0;
            tick          <= 1'b0;
        end else if (en) begin
            if (w_terminal) begin
                r_cnt         <= '0;
                clk_div       <= ~clk_div;
                // Rising toggle: tick lands on the first high cycle.
                tick          <= ~clk_div;
                // New value governs the half that starts at this edge.
                r_active_half <= w_next_half;
            end else begin
                r_cnt <= r_cnt + c_one;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Upstream stage of the 2-bit display-scan counter.
- Derives the slow scan clock `clk_div` from the board clock `clk`. The counter's first T flip-flop consumes `clk_div` directly as its clock.
- Also emits a one-cycle `tick` strobe, in the `clk` domain, on each rising edge of `clk_div`, for synchronous consumers.
- Half-period is runtime-programmable; changes are applied glitch-free at toggle boundaries.

Parameters:
- WIDTH, 26, bit width of the half-period counter and of the `half_period` input.
- DEFAULT_HALF, 25000, half-period (in `clk` cycles) loaded at reset (1 kHz `clk_div` from 50 MHz `clk`).

Ports:
- clk  input  1  board clock; all state is updated on its rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; 0 freezes the divider.
- half_period  input  WIDTH  requested half-period in `clk` cycles; 0 is treated as 1.
- clk_div  output  1  divided square wave: high for H cycles, low for H cycles (H = active half-period). Registered output.
- tick  output  1  one-`clk`-cycle pulse, asserted in the cycle `clk_div` first reads 1.

Behaviour:
- Interface:
  - One clock: `clk`.
  - Reset is synchronous and active-high, port `rst`.
- Internal state:
  - `cnt` [WIDTH], half-period counter.
  - `active_half` [WIDTH], half-period currently in use.
  - `clk_div` register.
  - `tick` register.
- Reset (rst=1 at a `clk` edge):
  - cnt=0, clk_div=0, tick=0, active_half=DEFAULT_HALF (0 is coerced to 1).
  - `rst` overrides `en` and any other input.
  - Reset mid-period discards the partial count; the next half-period restarts from 0 with DEFAULT_HALF.
- en=1, cnt != active_half-1:
  - cnt <= cnt+1; tick <= 0; clk_div holds.
- en=1, cnt == active_half-1 (toggle event):
  - cnt <= 0.
  - clk_div <= ~clk_div.
  - tick <= 1 if clk_div was 0 (rising toggle), else 0.
  - active_half <= (half_period==0) ? 1 : half_period.
- en=0:
  - cnt, clk_div and active_half hold; tick <= 0.
  - Resuming continues from the held count; no pulse is lost or duplicated.
- Latency:
  - `clk_div` and `tick` change together, on the same edge, one `clk` after the terminal count is reached.
  - `tick` is therefore coincident with the `clk_div` high phase's first cycle.
- Half-period changes:
  - `half_period` is sampled only at toggle events.
  - A change mid-half does not shorten or stretch the current half.
  - `cnt` can never exceed active_half-1, so there is no wrap past the terminal count.
- Minimum divide (active_half=1):
  - clk_div toggles every `clk` cycle (period 2).
  - tick pulses every 2nd cycle.
- Maximum: active_half = 2^WIDTH-1; the counter never overflows.
- Simultaneous toggle event and `half_period` change: the new value applies to the half that starts at that edge.
- `clk_div` is driven only from a flop, never from combinational logic, so it is glitch-free for use as a clock.

Test Plan:
- Reset/hold: DEFAULT_HALF=2, rst=1 for 3 cycles with en=1 → clk_div=0, tick=0 throughout; after release, clk_div rises on the 2nd edge, tick=1 for exactly that cycle.
- Steady divide: half_period=3, en=1 for 24 cycles after first toggle → clk_div shows 3 high / 3 low, period 6; tick fires 4 times, 6 cycles apart, each 1 cycle wide.
- Mid-half change: active_half=4; at cnt=1 set half_period=2 → current half still lasts 4 cycles; the following halves last 2.
- Zero/min: half_period=0 → after the next toggle, clk_div alternates every cycle and tick pulses every 2 cycles.
- Enable freeze: active_half=5; deassert en at cnt=2 for 7 cycles → clk_div and cnt frozen, tick=0; after re-enable, the toggle occurs 3 cycles later.
- Reset mid-operation: assert rst while clk_div=1, cnt=3 → next cycle clk_div=0, cnt=0, active_half=DEFAULT_HALF; when `clk_div` drives the 2-bit counter, it steps 00→01→10→11→00 on successive `clk_div` rising edges.
